// File: rtl/wb_pkg.sv
// Shared writeback-port definitions: requester count, source indices, default widths
// and the index-width helper used for pointer and source ports.
package wb_pkg;

  localparam int WB_NREQ    = 3;
  localparam int WB_AW      = 5;
  localparam int WB_XLEN    = 32;

  localparam int WB_SRC_EXU = 0;
  localparam int WB_SRC_LSU = 1;
  localparam int WB_SRC_CSR = 2;

  // Index width for an n-entry requester set; never narrower than one bit.
  function automatic int wb_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_port_arbiter_rr.sv
// Rotating-priority one-hot grant: lowest requester at/after the pointer wins,
// falling back to the lowest requester overall when nothing sits at/above the pointer.
module rr_arbiter
  import wb_pkg::*;
#(
  parameter int N = WB_NREQ,
  localparam int PW = wb_idx_w(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o
);

  logic [N-1:0] mask_s;
  logic [N-1:0] hi_req_s;

  assign mask_s   = ~((N'(1) << ptr_i) - N'(1));
  assign hi_req_s = req_i & mask_s;

  // x & -x isolates the lowest set bit, which is the scan-upward winner.
  always_comb begin
    if (hi_req_s != '0) begin
      gnt_o = hi_req_s & (~hi_req_s + N'(1));
    end else begin
      gnt_o = req_i & (~req_i + N'(1));
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Round-robin owner of the GPR write port: one grant per cycle, one registered
// write plus a one-cycle retire pulse per handshake.
module wb_port_arbiter
  import wb_pkg::*;
#(
  parameter int NREQ = WB_NREQ,
  parameter int XLEN = WB_XLEN,
  parameter int AW   = WB_AW,
  localparam int PW  = wb_idx_w(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ-1:0]      req_wen,
  input  logic [NREQ*AW-1:0]   req_rd,
  input  logic [NREQ*XLEN-1:0] req_data,
  output logic [NREQ-1:0]      req_ready,
  input  logic                 hold,
  output logic                 rf_wen,
  output logic [AW-1:0]        rf_waddr,
  output logic [XLEN-1:0]      rf_wdata,
  output logic                 retire_valid,
  output logic [PW-1:0]        retire_src
);

  logic [PW-1:0]   ptr_q, ptr_d;
  logic [NREQ-1:0] arb_gnt_s, grant_s;
  logic            any_s;
  logic [PW-1:0]   gnt_idx_s;
  logic            sel_wen_s;
  logic [AW-1:0]   sel_rd_s;
  logic [XLEN-1:0] sel_data_s;
  logic            rf_wen_q, retire_valid_q;
  logic [AW-1:0]   rf_waddr_q;
  logic [XLEN-1:0] rf_wdata_q;
  logic [PW-1:0]   retire_src_q;

  rr_arbiter #(.N(NREQ)) u_rr (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt_s)
  );

  // Gating by rst keeps a handshake from completing in a cycle whose result is discarded.
  assign grant_s   = (hold || rst) ? '0 : arb_gnt_s;
  assign any_s     = |grant_s;
  assign req_ready = grant_s;

  always_comb begin
    gnt_idx_s  = '0;
    sel_wen_s  = 1'b0;
    sel_rd_s   = '0;
    sel_data_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      gnt_idx_s  = gnt_idx_s  | (grant_s[i] ? PW'(i) : PW'(0));
      sel_wen_s  = sel_wen_s  | (grant_s[i] & req_wen[i]);
      sel_rd_s   = sel_rd_s   | (req_rd[i*AW +: AW]       & {AW{grant_s[i]}});
      sel_data_s = sel_data_s | (req_data[i*XLEN +: XLEN] & {XLEN{grant_s[i]}});
    end
  end

  always_comb begin
    if (!any_s) begin
      ptr_d = ptr_q;
    end else if (gnt_idx_s == PW'(NREQ - 1)) begin
      ptr_d = '0;
    end else begin
      ptr_d = gnt_idx_s + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q          <= '0;
      rf_wen_q       <= 1'b0;
      rf_waddr_q     <= '0;
      rf_wdata_q     <= '0;
      retire_valid_q <= 1'b0;
      retire_src_q   <= '0;
    end else begin
      ptr_q          <= ptr_d;
      rf_wen_q       <= any_s & sel_wen_s & (sel_rd_s != '0);
      retire_valid_q <= any_s;
      if (any_s) begin
        rf_waddr_q   <= sel_rd_s;
        rf_wdata_q   <= sel_data_s;
        retire_src_q <= gnt_idx_s;
      end else begin
        rf_waddr_q   <= rf_waddr_q;
        rf_wdata_q   <= rf_wdata_q;
        retire_src_q <= retire_src_q;
      end
    end
  end

  assign rf_wen       = rf_wen_q;
  assign rf_waddr     = rf_waddr_q;
  assign rf_wdata     = rf_wdata_q;
  assign retire_valid = retire_valid_q;
  assign retire_src   = retire_src_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: inputs change on the falling edge, outputs
// are compared on the falling edge with immediate assertions.
module tb_wb_port_arbiter;
  import wb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req_valid;
  logic [2:0]  req_wen;
  logic [14:0] req_rd;
  logic [95:0] req_data;
  logic [2:0]  req_ready;
  logic        hold;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        retire_valid;
  logic [1:0]  retire_src;

  int checks   = 0;
  int failures = 0;
  int pulses   = 0;

  logic [31:0] d3 [3];
  logic [2:0]  exp_gnt;

  wb_port_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_wen      (req_wen),
    .req_rd       (req_rd),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .hold         (hold),
    .rf_wen       (rf_wen),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .retire_valid (retire_valid),
    .retire_src   (retire_src)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic w,
                         input logic [4:0] rd, input logic [31:0] d);
    req_valid[i]         = v;
    req_wen[i]           = w;
    req_rd[i*5 +: 5]     = rd;
    req_data[i*32 +: 32] = d;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    d3[0] = 32'h1111_1111;
    d3[1] = 32'h2222_2222;
    d3[2] = 32'h3333_3333;
    hold = 1'b0;
    req_valid = 3'b000; req_wen = 3'b000; req_rd = 15'd0; req_data = 96'd0;

    // 1: reset with every requester valid
    rst = 1'b1;
    set_req(0, 1'b1, 1'b1, 5'd1, 32'hAAAA_0000);
    set_req(1, 1'b1, 1'b1, 5'd2, 32'hAAAA_0001);
    set_req(2, 1'b1, 1'b1, 5'd3, 32'hAAAA_0002);
    next_cycle();
    chk("rst1_ready", 64'(req_ready), 64'd0);
    chk("rst1_wen", 64'(rf_wen), 64'd0);
    chk("rst1_retire", 64'(retire_valid), 64'd0);
    next_cycle();
    chk("rst2_ready", 64'(req_ready), 64'd0);
    chk("rst2_wen", 64'(rf_wen), 64'd0);
    chk("rst2_retire", 64'(retire_valid), 64'd0);
    chk("rst2_waddr", 64'(rf_waddr), 64'd0);
    chk("rst2_wdata", 64'(rf_wdata), 64'd0);
    chk("rst2_src", 64'(retire_src), 64'd0);
    rst = 1'b0;
    req_valid = 3'b000;
    next_cycle();
    chk("postrst_wen", 64'(rf_wen), 64'd0);
    chk("postrst_retire", 64'(retire_valid), 64'd0);

    // 2: single LSU writeback
    set_req(WB_SRC_LSU, 1'b1, 1'b1, 5'd5, 32'hDEAD_BEEF);
    #1 chk("single_ready", 64'(req_ready), 64'b010);
    next_cycle();
    req_valid = 3'b000;
    chk("single_wen", 64'(rf_wen), 64'd1);
    chk("single_waddr", 64'(rf_waddr), 64'd5);
    chk("single_wdata", 64'(rf_wdata), 64'hDEAD_BEEF);
    chk("single_retire", 64'(retire_valid), 64'd1);
    chk("single_src", 64'(retire_src), 64'd1);
    next_cycle();
    chk("single_pulse_end", 64'(retire_valid), 64'd0);
    chk("single_wen_end", 64'(rf_wen), 64'd0);
    chk("single_waddr_hold", 64'(rf_waddr), 64'd5);

    // pointer back to 0 before the contention run
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;

    // 3: contention, all three valid for six cycles
    for (int i = 0; i < 3; i++) set_req(i, 1'b1, 1'b1, 5'(i + 1), d3[i]);
    for (int k = 0; k < 6; k++) begin
      exp_gnt = 3'b001 << (k % 3);
      #1 chk($sformatf("cont%0d_ready", k), 64'(req_ready), 64'(exp_gnt));
      next_cycle();
      if (retire_valid === 1'b1) pulses++;
      chk($sformatf("cont%0d_src", k), 64'(retire_src), 64'(k % 3));
      chk($sformatf("cont%0d_waddr", k), 64'(rf_waddr), 64'((k % 3) + 1));
      chk($sformatf("cont%0d_wdata", k), 64'(rf_wdata), 64'(d3[k % 3]));
    end
    req_valid = 3'b000;
    chk("cont_pulses", 64'(pulses), 64'd6);

    // 4: rd=x0 write and a non-writing CSR instruction
    set_req(WB_SRC_EXU, 1'b1, 1'b1, 5'd0, 32'h1234_5678);
    #1 chk("x0_ready", 64'(req_ready), 64'b001);
    next_cycle();
    req_valid = 3'b000;
    chk("x0_retire", 64'(retire_valid), 64'd1);
    chk("x0_src", 64'(retire_src), 64'd0);
    chk("x0_wen", 64'(rf_wen), 64'd0);
    set_req(WB_SRC_CSR, 1'b1, 1'b0, 5'd7, 32'h0BAD_F00D);
    #1 chk("nowr_ready", 64'(req_ready), 64'b100);
    next_cycle();
    req_valid = 3'b000;
    chk("nowr_retire", 64'(retire_valid), 64'd1);
    chk("nowr_src", 64'(retire_src), 64'd2);
    chk("nowr_wen", 64'(rf_wen), 64'd0);
    chk("nowr_waddr", 64'(rf_waddr), 64'd7);
    next_cycle();

    // 5: hold for three cycles with requesters 0 and 2 pending
    hold = 1'b1;
    set_req(0, 1'b1, 1'b1, 5'd10, 32'h0000_00A0);
    set_req(2, 1'b1, 1'b1, 5'd12, 32'h0000_00C2);
    for (int k = 0; k < 3; k++) begin
      #1 chk($sformatf("hold%0d_ready", k), 64'(req_ready), 64'd0);
      next_cycle();
      chk($sformatf("hold%0d_retire", k), 64'(retire_valid), 64'd0);
    end
    hold = 1'b0;
    #1 chk("rel0_ready", 64'(req_ready), 64'b001);
    next_cycle();
    req_valid[0] = 1'b0;
    chk("rel0_src", 64'(retire_src), 64'd0);
    chk("rel0_wdata", 64'(rf_wdata), 64'h0000_00A0);
    #1 chk("rel2_ready", 64'(req_ready), 64'b100);
    next_cycle();
    req_valid[2] = 1'b0;
    chk("rel2_src", 64'(retire_src), 64'd2);
    chk("rel2_waddr", 64'(rf_waddr), 64'd12);

    // 6: reset during a grant to idx2, with the pointer moved off zero first
    set_req(1, 1'b1, 1'b1, 5'd9, 32'h0000_0091);
    next_cycle();
    req_valid = 3'b000;
    set_req(2, 1'b1, 1'b1, 5'd13, 32'h0000_00D2);
    #1 chk("mid_ready", 64'(req_ready), 64'b100);
    rst = 1'b1;
    next_cycle();
    chk("mid_retire", 64'(retire_valid), 64'd0);
    chk("mid_wen", 64'(rf_wen), 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) set_req(i, 1'b1, 1'b1, 5'(i + 20), d3[i]);
    #1 chk("mid_next_ready", 64'(req_ready), 64'b001);
    next_cycle();
    req_valid = 3'b000;
    chk("mid_next_src", 64'(retire_src), 64'd0);
    chk("mid_next_retire", 64'(retire_valid), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
